// File: rtl/amber_irq_round_robin_sched.sv
// Round-robin interrupt scheduler.
// Picks one pending source at a time, presents it to the core, and tracks
// it through acknowledge and end-of-interrupt. Arbitration starts searching
// just past the last serviced source so every pending source gets its turn.

module amber_irq_round_robin_sched #(
  parameter int N_SRC = 32,
  parameter int VW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_irq_pend,
  input  logic             i_ack,
  input  logic             i_eoi,
  output logic             o_irq,
  output logic [VW-1:0]    o_vector,
  output logic [N_SRC-1:0] o_in_service,
  output logic             o_spurious,
  output logic [15:0]      o_grant_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } stateT;

  // Registered state and datapath
  stateT             r_state;
  logic [VW-1:0]     r_rrPtr;
  logic [VW-1:0]     r_winner;
  logic              r_irq;
  logic [N_SRC-1:0]  r_inService;
  logic              r_spurious;
  logic [15:0]       r_grantCount;

  // Next-state values and helper decodes
  stateT             w_stateNext;
  logic [VW-1:0]     w_rrPtrNext;
  logic [VW-1:0]     w_winnerNext;
  logic [N_SRC-1:0]  w_inServiceNext;
  logic              w_spuriousNext;
  logic [15:0]       w_grantCountNext;

  logic              w_found;
  logic [VW-1:0]     w_searchIdx;
  logic              w_winnerPending;
  logic [VW-1:0]     w_winnerInc;
  logic [N_SRC-1:0]  w_winnerOneHot;

  // The winner's own request line decides between grant, withdrawal and spurious ack
  assign w_winnerPending = i_irq_pend[r_winner];

  // Pointer advance past the winner; explicit wrap keeps non-power-of-two counts in range
  assign w_winnerInc = (r_winner == VW'(N_SRC - 1)) ? '0 : (r_winner + 1'b1);

  // One-hot flag for the source being serviced
  assign w_winnerOneHot = {{(N_SRC-1){1'b0}}, 1'b1} << r_winner;

  // Circular search: first pending source at or above the round-robin pointer, wrapping to 0
  always_comb begin : searchBlk
    logic [VW:0] idx;
    w_found     = 1'b0;
    w_searchIdx = '0;
    idx         = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, r_rrPtr} + (VW+1)'(k);
      if (idx >= (VW+1)'(N_SRC)) begin
        idx = idx - (VW+1)'(N_SRC);
      end
      if (!w_found && i_irq_pend[idx[VW-1:0]]) begin
        w_found     = 1'b1;
        w_searchIdx = idx[VW-1:0];
      end
    end
  end

  // Next-state and datapath decisions; only the pulse legal in the current state has any effect
  always_comb begin
    w_stateNext      = r_state;
    w_rrPtrNext      = r_rrPtr;
    w_winnerNext     = r_winner;
    w_inServiceNext  = r_inService;
    w_spuriousNext   = 1'b0;
    w_grantCountNext = r_grantCount;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_winnerNext = w_searchIdx;
          w_stateNext  = PEND;
        end
      end

      PEND: begin
        if (i_ack) begin
          if (w_winnerPending) begin
            w_stateNext      = ACTIVE;
            w_inServiceNext  = w_winnerOneHot;
            w_grantCountNext = r_grantCount + 16'd1;
          end else begin
            w_stateNext    = IDLE;
            w_spuriousNext = 1'b1;
          end
        end else if (!w_winnerPending) begin
          w_stateNext = IDLE;
        end
      end

      ACTIVE: begin
        if (i_eoi) begin
          w_stateNext     = IDLE;
          w_inServiceNext = '0;
          w_rrPtrNext     = w_winnerInc;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction outright
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_rrPtr      <= '0;
      r_winner     <= '0;
      r_irq        <= 1'b0;
      r_inService  <= '0;
      r_spurious   <= 1'b0;
      r_grantCount <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_rrPtr      <= w_rrPtrNext;
      r_winner     <= w_winnerNext;
      r_irq        <= (w_stateNext == PEND);
      r_inService  <= w_inServiceNext;
      r_spurious   <= w_spuriousNext;
      r_grantCount <= w_grantCountNext;
    end
  end

  assign o_irq         = r_irq;
  assign o_vector      = r_winner;
  assign o_in_service  = r_inService;
  assign o_spurious    = r_spurious;
  assign o_grant_count = r_grantCount;

endmodule

// File: tb/tb_amber_irq_round_robin_sched.sv
// Directed self-checking bench for the round-robin interrupt scheduler.
// Expected values are hand-derived; a tiny grant-count model tracks grants.

module tb_amber_irq_round_robin_sched;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_irq_pend;
  logic        i_ack;
  logic        i_eoi;
  logic        o_irq;
  logic [4:0]  o_vector;
  logic [31:0] o_in_service;
  logic        o_spurious;
  logic [15:0] o_grant_count;

  int nChecks;
  int nErrors;
  int expCount;

  amber_irq_round_robin_sched #(
    .N_SRC(32),
    .VW   (5)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_irq_pend   (i_irq_pend),
    .i_ack        (i_ack),
    .i_eoi        (i_eoi),
    .o_irq        (o_irq),
    .o_vector     (o_vector),
    .o_in_service (o_in_service),
    .o_spurious   (o_spurious),
    .o_grant_count(o_grant_count)
  );

  // Free-running clock, 10 ns period
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Compares one observed value against its expected value and tallies the result
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and returns just after the following rising edge
  task automatic applyStimulus(input logic [31:0] pend, input logic ack, input logic eoi);
    i_irq_pend = pend;
    i_ack      = ack;
    i_eoi      = eoi;
    @(posedge i_clk);
    #1;
  endtask

  // Full present / ack / eoi transaction for one expected vector
  task automatic serviceOne(input logic [31:0] pend, input int expVec, input string tag);
    applyStimulus(pend, 1'b0, 1'b0);
    checkOutput({tag, "_irq"}, 32'(o_irq), 32'd1);
    checkOutput({tag, "_vec"}, 32'(o_vector), 32'(expVec));
    applyStimulus(pend, 1'b1, 1'b0);
    expCount++;
    checkOutput({tag, "_ackIrq"}, 32'(o_irq), 32'd0);
    checkOutput({tag, "_inSvc"}, o_in_service, 32'd1 << expVec);
    checkOutput({tag, "_count"}, 32'(o_grant_count), 32'(expCount & 16'hFFFF));
    applyStimulus(pend, 1'b0, 1'b1);
    checkOutput({tag, "_eoiInSvc"}, o_in_service, 32'd0);
  endtask

  initial begin
    nChecks    = 0;
    nErrors    = 0;
    expCount   = 0;
    i_rst      = 1'b0;
    i_irq_pend = '0;
    i_ack      = 1'b0;
    i_eoi      = 1'b0;

    // Reset values
    #1 i_rst = 1'b1;
    #1;
    checkOutput("rst_irq",   32'(o_irq),         32'd0);
    checkOutput("rst_vec",   32'(o_vector),      32'd0);
    checkOutput("rst_inSvc", o_in_service,       32'd0);
    checkOutput("rst_spur",  32'(o_spurious),    32'd0);
    checkOutput("rst_count", 32'(o_grant_count), 32'd0);
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // No arbitration while nothing is pending
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("idle_irq", 32'(o_irq), 32'd0);

    // Round robin between sources 1 and 2
    serviceOne(32'h0000_0006, 1, "rr0");
    serviceOne(32'h0000_0006, 2, "rr1");
    serviceOne(32'h0000_0006, 1, "rr2");
    serviceOne(32'h0000_0006, 2, "rr3");
    checkOutput("rr_count4", 32'(o_grant_count), 32'd4);

    // Pointer wrap: grant 30 leaves pointer at 31, then 31 and 0 in turn
    serviceOne(32'h4000_0000, 30, "wrap30");
    serviceOne(32'h8000_0001, 31, "wrap31");
    serviceOne(32'h8000_0001, 0,  "wrap0");

    // Source 5 withdraws before ack
    applyStimulus(32'h0000_0020, 1'b0, 1'b0);
    checkOutput("wd_irq",   32'(o_irq),    32'd1);
    checkOutput("wd_vec",   32'(o_vector), 32'd5);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("wd_dropIrq", 32'(o_irq),         32'd0);
    checkOutput("wd_count",   32'(o_grant_count), 32'(expCount));
    checkOutput("wd_spur",    32'(o_spurious),    32'd0);

    // Same, but ack arrives on the drop cycle: spurious
    applyStimulus(32'h0000_0020, 1'b0, 1'b0);
    checkOutput("sp_vec", 32'(o_vector), 32'd5);
    applyStimulus(32'h0, 1'b1, 1'b0);
    checkOutput("sp_spur",  32'(o_spurious),    32'd1);
    checkOutput("sp_irq",   32'(o_irq),         32'd0);
    checkOutput("sp_count", 32'(o_grant_count), 32'(expCount));
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("sp_spurPulse", 32'(o_spurious), 32'd0);
    checkOutput("sp_vecHold",   32'(o_vector),   32'd5);

    // Hold winner 8 in PEND despite source 3 arriving; ignore eoi in PEND
    applyStimulus(32'h0000_0100, 1'b0, 1'b0);
    checkOutput("hold_vec8", 32'(o_vector), 32'd8);
    applyStimulus(32'h0000_0108, 1'b0, 1'b0);
    checkOutput("hold_vecStay", 32'(o_vector), 32'd8);
    checkOutput("hold_irq",     32'(o_irq),    32'd1);
    applyStimulus(32'h0000_0108, 1'b0, 1'b1);
    checkOutput("hold_eoiPendIrq",   32'(o_irq),   32'd1);
    checkOutput("hold_eoiPendInSvc", o_in_service, 32'd0);
    applyStimulus(32'h0000_0108, 1'b1, 1'b0);
    expCount++;
    checkOutput("act_inSvc", o_in_service,        32'h0000_0100);
    checkOutput("act_count", 32'(o_grant_count),  32'(expCount));
    applyStimulus(32'h0000_0108, 1'b1, 1'b0);
    checkOutput("act_reAckInSvc", o_in_service,       32'h0000_0100);
    checkOutput("act_reAckIrq",   32'(o_irq),         32'd0);
    checkOutput("act_reAckCount", 32'(o_grant_count), 32'(expCount));
    applyStimulus(32'h0000_0108, 1'b1, 1'b1);
    checkOutput("act_eoiInSvc", o_in_service,       32'd0);
    checkOutput("act_eoiCount", 32'(o_grant_count), 32'(expCount));
    applyStimulus(32'h0, 1'b0, 1'b1);
    checkOutput("idle_eoiIrq", 32'(o_irq), 32'd0);
    // Pointer now sits at 9, so source 3 wins over source 8
    serviceOne(32'h0000_0108, 3, "after8");

    // Asynchronous reset in the middle of ACTIVE
    applyStimulus(32'h0000_0400, 1'b0, 1'b0);
    checkOutput("ar_vec10", 32'(o_vector), 32'd10);
    applyStimulus(32'h0000_0400, 1'b1, 1'b0);
    checkOutput("ar_inSvc", o_in_service, 32'h0000_0400);
    #2;
    i_rst      = 1'b1;
    i_irq_pend = '0;
    i_ack      = 1'b0;
    i_eoi      = 1'b0;
    #1;
    checkOutput("ar_rstInSvc", o_in_service,       32'd0);
    checkOutput("ar_rstIrq",   32'(o_irq),         32'd0);
    checkOutput("ar_rstCount", 32'(o_grant_count), 32'd0);
    checkOutput("ar_rstVec",   32'(o_vector),      32'd0);
    expCount = 0;
    #1 i_rst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("ar_idleIrq", 32'(o_irq), 32'd0);
    // Pointer back at 0: source 0 wins over source 20
    serviceOne(32'h0010_0001, 0, "ar_ptr0");

    // Fairness with every source pending: grants walk upward from the pointer
    for (int i = 0; i < 40; i++) begin
      serviceOne(32'hFFFF_FFFF, (1 + i) % 32, $sformatf("fair%0d", i));
    end
    checkOutput("fair_count", 32'(o_grant_count), 32'd41);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
